// File: rtl/fsk_pkg.sv
// fsk_pkg: constants and types shared by the FSK receive path and the transmit-side modulator.
//   - ADC frame geometry (ADC_W data bits carried in a FRAME_BITS-clock serial frame)
//   - default demodulator thresholds
//   - mark/space tone frequencies and bit rate, common to modulator and demodulator
//   - ADC reader state encoding
//   - hysteresis level helper used by the crossing detector
package fsk_pkg;

  localparam int unsigned ADC_W      = 12;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ZC_W       = 8;

  localparam int unsigned MIDSCALE_DEF  = 2048;
  localparam int unsigned HYST_DEF      = 64;
  localparam int unsigned ZC_THRESH_DEF = 15;

  // Tone plan shared with the modulator: mark = 1, space = 0.
  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned MARK_HZ  = 100_000;
  localparam int unsigned SPACE_HZ = 50_000;
  localparam int unsigned BAUD_HZ  = 10_000;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CONV = 2'd1,
    RD_DONE = 2'd2
  } rd_state_t;

  // Schmitt-trigger style level: above hi_th -> 1, below lo_th -> 0, otherwise hold.
  // Operands are one bit wider than a sample so the thresholds never wrap.
  function automatic logic level_update(
    input logic [ADC_W:0] s,
    input logic [ADC_W:0] hi_th,
    input logic [ADC_W:0] lo_th,
    input logic           cur
  );
    logic nxt;
    if (s >= hi_th) begin
      nxt = 1'b1;
    end else if (s <= lo_th) begin
      nxt = 1'b0;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fsk_demod_adc_if.sv
// fsk_demod_adc_if: bundles the serial ADC pins and the demodulator result stream.
//   master (demodulator side): drives sclk_adc, cs_adc, sample, sample_valid,
//                              bit_out, bit_valid, zc_count; reads miso_adc
//   slave  (ADC / consumer side): drives miso_adc; reads everything else
interface fsk_demod_adc_if;
  import fsk_pkg::*;

  logic                 miso_adc;
  logic                 sclk_adc;
  logic                 cs_adc;
  logic [ADC_W-1:0]     sample;
  logic                 sample_valid;
  logic                 bit_out;
  logic                 bit_valid;
  logic [ZC_W-1:0]      zc_count;

  modport master (
    input  miso_adc,
    output sclk_adc, cs_adc, sample, sample_valid, bit_out, bit_valid, zc_count
  );

  modport slave (
    output miso_adc,
    input  sclk_adc, cs_adc, sample, sample_valid, bit_out, bit_valid, zc_count
  );

endinterface

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: reads one frame from a 12-bit serial ADC per start request.
//   clk, reset (async active-low)
//   start : request a conversion; honoured only while idle
//   miso  : ADC serial data, captured on each SCLK rise
//   sclk  : serial clock, idles high, first edge of a frame is a fall
//   cs    : chip select, active-low, low for exactly 32*SCLK_DIV clk cycles
//   data  : low ADC_W bits of the last frame (leading bits are discarded)
//   valid : one-cycle pulse, the cycle after the last SCLK rise
module adc_spi_reader
  import fsk_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             miso,
  output logic             sclk,
  output logic             cs,
  output logic [ADC_W-1:0] data,
  output logic             valid
);

  localparam int unsigned DIV_W  = $clog2(SCLK_DIV + 1);
  localparam int unsigned RISE_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(FRAME_BITS - 1);

  rd_state_t               state;
  logic [DIV_W-1:0]        div_cnt;
  logic [RISE_W-1:0]       rise_cnt;
  // The first leading zero falls off the top; only FRAME_BITS-1 bits are kept.
  logic [FRAME_BITS-2:0]   shift;

  // Frame sequencer: SCLK generation, bit capture and result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RD_IDLE;
      sclk     <= 1'b1;
      cs       <= 1'b1;
      div_cnt  <= '0;
      rise_cnt <= '0;
      shift    <= '0;
      data     <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        RD_IDLE: begin
          sclk     <= 1'b1;
          div_cnt  <= '0;
          rise_cnt <= '0;
          if (start) begin
            state <= RD_CONV;
            cs    <= 1'b0;
          end else begin
            cs    <= 1'b1;
          end
        end
        RD_CONV: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            // sclk low now means this toggle is a rising edge.
            if (!sclk) begin
              shift    <= {shift[FRAME_BITS-3:0], miso};
              rise_cnt <= rise_cnt + RISE_W'(1);
              if (rise_cnt == RISE_LAST) begin
                state <= RD_DONE;
                cs    <= 1'b1;
              end else begin
                cs    <= 1'b0;
              end
            end else begin
              cs <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        RD_DONE: begin
          data  <= shift[ADC_W-1:0];
          valid <= 1'b1;
          state <= RD_IDLE;
        end
        default: begin
          state <= RD_IDLE;
          sclk  <= 1'b1;
          cs    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fsk_demod_adc.sv
// fsk_demod_adc: FSK demodulator fed by a serial ADC.
//   clk, reset (async active-low), en (enables conversions and demodulation)
//   bus (master modport):
//     miso_adc/sclk_adc/cs_adc : serial ADC pins
//     sample, sample_valid     : last captured sample and its update pulse
//     bit_out, bit_valid       : recovered bit per window and its update pulse
//     zc_count                 : running crossing count of the current window
// A conversion starts every SAMPLE_PERIOD clocks while enabled. Each sample
// is passed through a hysteresis comparator around MIDSCALE; level changes are
// counted over SAMPLES_PER_BIT samples and a window with at least ZC_THRESH
// crossings decodes as 1 (the higher mark tone crosses more often).
module fsk_demod_adc
  import fsk_pkg::*;
#(
  parameter int unsigned SCLK_DIV        = 4,
  parameter int unsigned SAMPLE_PERIOD   = 200,
  parameter int unsigned SAMPLES_PER_BIT = 50,
  parameter int unsigned MIDSCALE        = MIDSCALE_DEF,
  parameter int unsigned HYST            = HYST_DEF,
  parameter int unsigned ZC_THRESH       = ZC_THRESH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  fsk_demod_adc_if.master bus
);

  localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
  localparam int unsigned WW = $clog2(SAMPLES_PER_BIT + 1);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [WW-1:0]    WIN_LAST   = WW'(SAMPLES_PER_BIT - 1);
  localparam logic [ADC_W:0]   HI_TH      = (ADC_W + 1)'(MIDSCALE + HYST);
  localparam logic [ADC_W:0]   LO_TH      = (ADC_W + 1)'(MIDSCALE - HYST);
  localparam logic [ZC_W-1:0]  ZC_MAX     = {ZC_W{1'b1}};
  localparam logic [ZC_W-1:0]  ZC_TH      = ZC_W'(ZC_THRESH);

  logic [TW-1:0]      timer;
  logic               start;
  logic [ADC_W-1:0]   rd_data;
  logic               rd_valid;
  logic               rd_sclk;
  logic               rd_cs;

  logic               level_hi;
  logic               level_next;
  logic               crossing;
  logic [WW-1:0]      win_cnt;
  logic [ZC_W-1:0]    zc;
  logic [ZC_W-1:0]    zc_next;
  logic               bit_q;
  logic               bit_vld;

  // Conversion pacing timer, free-running regardless of en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (timer == TIMER_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // The reader ignores start while a frame is in progress.
  assign start = en && (timer == TIMER_LAST);

  adc_spi_reader #(
    .SCLK_DIV (SCLK_DIV)
  ) u_reader (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .miso  (bus.miso_adc),
    .sclk  (rd_sclk),
    .cs    (rd_cs),
    .data  (rd_data),
    .valid (rd_valid)
  );

  // Crossing detection and saturating count for the incoming sample.
  always_comb begin
    level_next = level_update({1'b0, rd_data}, HI_TH, LO_TH, level_hi);
    crossing   = (level_next != level_hi);
    if (crossing && (zc != ZC_MAX)) begin
      zc_next = zc + ZC_W'(1);
    end else begin
      zc_next = zc;
    end
  end

  // Window accounting and bit decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_hi <= 1'b0;
      win_cnt  <= '0;
      zc       <= '0;
      bit_q    <= 1'b0;
      bit_vld  <= 1'b0;
    end else begin
      bit_vld <= 1'b0;
      if (!en) begin
        level_hi <= 1'b0;
        win_cnt  <= '0;
        zc       <= '0;
      end else if (rd_valid) begin
        // level_hi carries across windows so a tone does not fake a crossing at each boundary.
        level_hi <= level_next;
        if (win_cnt == WIN_LAST) begin
          bit_q   <= (zc_next >= ZC_TH);
          bit_vld <= 1'b1;
          zc      <= '0;
          win_cnt <= '0;
        end else begin
          zc      <= zc_next;
          win_cnt <= win_cnt + WW'(1);
        end
      end else begin
        level_hi <= level_hi;
      end
    end
  end

  assign bus.sclk_adc     = rd_sclk;
  assign bus.cs_adc       = rd_cs;
  assign bus.sample       = rd_data;
  assign bus.sample_valid = rd_valid;
  assign bus.bit_out      = bit_q;
  assign bus.bit_valid    = bit_vld;
  assign bus.zc_count     = zc;

endmodule
